// File: rtl/core_memory_responder_if.sv
// Core-side instruction and data bus bundle for core_memory_responder.
// The core drives the master view; the memory responder takes the slave view.
interface core_memory_responder_if;
    logic        flush_bus;
    logic        instruction_request;
    logic        instruction_response;
    logic [31:0] instruction_data;
    logic [31:0] instruction_address;
    logic        data_memory_read;
    logic        data_memory_write;
    logic        data_memory_response;
    logic [31:0] read_data;
    logic [31:0] data_address;
    logic [31:0] write_data;

    modport master (
        output flush_bus, instruction_request, instruction_address,
               data_memory_read, data_memory_write, data_address, write_data,
        input  instruction_response, instruction_data, data_memory_response, read_data
    );

    modport slave (
        input  flush_bus, instruction_request, instruction_address,
               data_memory_read, data_memory_write, data_address, write_data,
        output instruction_response, instruction_data, data_memory_response, read_data
    );
endinterface

// File: rtl/core_memory_responder.sv
// Serves the core's instruction and data buses from one single-port word RAM.
// Data bus has fixed priority; optional wait states; flush kills in-flight fetches.
module core_memory_responder #(
    parameter int    MEM_WORDS   = 4096,
    parameter int    WAIT_STATES = 0,
    parameter string INIT_FILE   = ""
) (
    input  logic                      clk,
    input  logic                      rst,
    core_memory_responder_if.slave    bus
);
    localparam int AW = $clog2(MEM_WORDS);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_RESP} state_t;
    typedef enum logic [1:0] {G_NONE, G_INSTR, G_DATA} grant_t;

    state_t         r_state, w_state_next;
    grant_t         r_grant, w_grant_next;
    logic [3:0]     r_cnt, w_cnt_next;
    logic           r_is_write, r_in_range, r_killed;
    logic [AW-1:0]  r_idx;
    logic [31:0]    r_wdata, r_ram_q, r_instr_data, r_read_data;
    logic [31:0]    r_mem [MEM_WORDS];

    logic           w_data_req, w_grant_data, w_grant_instr;
    logic           w_instr_fire, w_data_fire, w_in_range;
    logic [31:0]    w_sel_addr;

    assign w_data_req    = bus.data_memory_read | bus.data_memory_write;
    assign w_grant_data  = (r_state == S_IDLE) && w_data_req;
    assign w_grant_instr = (r_state == S_IDLE) && !w_data_req &&
                           bus.instruction_request && !bus.flush_bus;
    assign w_sel_addr    = w_data_req ? bus.data_address : bus.instruction_address;
    assign w_in_range    = (w_sel_addr >> (AW + 2)) == 32'd0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_grant <= G_NONE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_grant <= w_grant_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // NOTE: every signal gets a default first so no path through the case can infer a latch.
    always_comb begin
        w_state_next = r_state;
        w_grant_next = r_grant;
        w_cnt_next   = r_cnt;
        w_instr_fire = 1'b0;
        w_data_fire  = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (w_grant_data || w_grant_instr) begin
                    w_grant_next = w_grant_data ? G_DATA : G_INSTR;
                    if (WAIT_STATES > 0) begin
                        w_state_next = S_WAIT;
                        w_cnt_next   = 4'(WAIT_STATES);
                    end else begin
                        w_state_next = S_ACCESS;
                    end
                end
            end
            S_WAIT: begin
                w_cnt_next = r_cnt - 4'd1;
                if (r_cnt == 4'd1) w_state_next = S_ACCESS;
            end
            S_ACCESS: w_state_next = S_RESP;
            S_RESP: begin
                // A flush seen in the response cycle itself still suppresses the fetch.
                w_instr_fire = (r_grant == G_INSTR) && !r_killed && !bus.flush_bus;
                w_data_fire  = (r_grant == G_DATA);
                w_state_next = S_IDLE;
                w_grant_next = G_NONE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_killed     <= 1'b0;
            r_instr_data <= '0;
            r_read_data  <= '0;
        end else begin
            if (r_state == S_IDLE)
                r_killed <= 1'b0;
            else if (r_grant == G_INSTR && bus.flush_bus)
                r_killed <= 1'b1;
            if (w_instr_fire)                r_instr_data <= r_ram_q;
            if (w_data_fire && !r_is_write)  r_read_data  <= r_ram_q;
        end
    end

    always_ff @(posedge clk) begin
        if (w_grant_data || w_grant_instr) begin
            r_idx      <= w_sel_addr[AW+1:2];
            r_in_range <= w_in_range;
            r_wdata    <= bus.write_data;
            r_is_write <= w_grant_data && bus.data_memory_write;
        end
    end

    // NOTE: the RAM array is deliberately not reset; reset only blocks a pending write.
    always_ff @(posedge clk) begin
        if (!rst && r_state == S_ACCESS) begin
            if (r_grant == G_DATA && r_is_write) begin
                if (r_in_range) r_mem[r_idx] <= r_wdata;
            end else begin
                r_ram_q <= r_in_range ? r_mem[r_idx] : 32'd0;
            end
        end
    end

    assign bus.instruction_response = w_instr_fire;
    assign bus.instruction_data     = w_instr_fire ? r_ram_q : r_instr_data;
    assign bus.data_memory_response = w_data_fire;
    assign bus.read_data            = (w_data_fire && !r_is_write) ? r_ram_q : r_read_data;
endmodule

// File: tb/tb_core_memory_responder.sv
// Bench for core_memory_responder: dut 0 has 16 words / no wait states,
// dut 1 has 64 words / 3 wait states; responses are checked against scoreboard queues.
module tb_core_memory_responder;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    core_memory_responder_if bus_a ();
    core_memory_responder_if bus_b ();

    core_memory_responder #(.MEM_WORDS(16), .WAIT_STATES(0)) dut_a (
        .clk(clk), .rst(rst), .bus(bus_a.slave));
    core_memory_responder #(.MEM_WORDS(64), .WAIT_STATES(3)) dut_b (
        .clk(clk), .rst(rst), .bus(bus_b.slave));

    logic        flush [2], ireq [2], dr [2], dw [2];
    logic [31:0] iaddr [2], daddr [2], wd [2];
    logic        iresp [2], dresp [2];
    logic [31:0] idata [2], rdata [2];

    assign bus_a.flush_bus           = flush[0];
    assign bus_a.instruction_request = ireq[0];
    assign bus_a.instruction_address = iaddr[0];
    assign bus_a.data_memory_read    = dr[0];
    assign bus_a.data_memory_write   = dw[0];
    assign bus_a.data_address        = daddr[0];
    assign bus_a.write_data          = wd[0];
    assign bus_b.flush_bus           = flush[1];
    assign bus_b.instruction_request = ireq[1];
    assign bus_b.instruction_address = iaddr[1];
    assign bus_b.data_memory_read    = dr[1];
    assign bus_b.data_memory_write   = dw[1];
    assign bus_b.data_address        = daddr[1];
    assign bus_b.write_data          = wd[1];
    assign iresp[0] = bus_a.instruction_response;
    assign idata[0] = bus_a.instruction_data;
    assign dresp[0] = bus_a.data_memory_response;
    assign rdata[0] = bus_a.read_data;
    assign iresp[1] = bus_b.instruction_response;
    assign idata[1] = bus_b.instruction_data;
    assign dresp[1] = bus_b.data_memory_response;
    assign rdata[1] = bus_b.read_data;

    int n_pass = 0;
    int n_total = 0;
    logic [32:0] qd0 [$], qd1 [$];
    logic [31:0] qi0 [$], qi1 [$];
    logic [31:0] last_rd [2];
    logic [31:0] last_id [2];

    typedef struct {
        int          s;
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    endtask

    function automatic int ws(input int s);
        return (s == 1) ? 3 : 0;
    endfunction

    always @(negedge clk) begin
        logic [32:0] e;
        logic [31:0] ei;
        if (!rst) begin
            for (int s = 0; s < 2; s++) begin
                if (iresp[s] || dresp[s])
                    check("resp mutex", {31'd0, iresp[s] & dresp[s]}, 32'd0);
                if (dresp[s]) begin
                    if ((s == 0 && qd0.size() == 0) || (s == 1 && qd1.size() == 0)) begin
                        n_total++;
                        $display("FAIL unexpected data response dut%0d at %0t", s, $time);
                    end else begin
                        if (s == 0) e = qd0.pop_front(); else e = qd1.pop_front();
                        check(e[32] ? "read_data held on store" : "read_data", rdata[s], e[31:0]);
                    end
                end
                if (iresp[s]) begin
                    if ((s == 0 && qi0.size() == 0) || (s == 1 && qi1.size() == 0)) begin
                        n_total++;
                        $display("FAIL unexpected instruction response dut%0d at %0t", s, $time);
                    end else begin
                        if (s == 0) ei = qi0.pop_front(); else ei = qi1.pop_front();
                        check("instruction_data", idata[s], ei);
                    end
                end
            end
        end
    end

    task automatic data_txn(input int s, input bit wr, input logic [31:0] a,
                            input logic [31:0] wdv, input logic [31:0] expv);
        logic [32:0] e;
        int k;
        if (!wr) last_rd[s] = expv;
        e = {wr, last_rd[s]};
        if (s == 0) qd0.push_back(e); else qd1.push_back(e);
        @(negedge clk);
        dw[s] = wr; dr[s] = !wr; daddr[s] = a; wd[s] = wdv;
        k = 0;
        do begin
            @(posedge clk); #1; k++;
        end while (!dresp[s] && k < 20);
        dw[s] = 1'b0; dr[s] = 1'b0;
        check("data latency", k, 2 + ws(s));
        @(posedge clk);
    endtask

    task automatic instr_txn(input int s, input logic [31:0] a, input logic [31:0] expv);
        int k;
        last_id[s] = expv;
        if (s == 0) qi0.push_back(expv); else qi1.push_back(expv);
        @(negedge clk);
        ireq[s] = 1'b1; iaddr[s] = a;
        k = 0;
        do begin
            @(posedge clk); #1; k++;
        end while (!iresp[s] && k < 20);
        ireq[s] = 1'b0;
        check("fetch latency", k, 2 + ws(s));
        @(posedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs [15];
        int k, t_d, t_i, seen;

        vecs[0]  = '{0, 1'b1, 32'h10,       32'hDEADBEEF, 32'h0};
        vecs[1]  = '{0, 1'b0, 32'h10,       32'h0,        32'hDEADBEEF};
        vecs[2]  = '{0, 1'b1, 32'h00,       32'h11112222, 32'h0};
        vecs[3]  = '{0, 1'b1, 32'h40,       32'h12345678, 32'h0};
        vecs[4]  = '{0, 1'b0, 32'h40,       32'h0,        32'h0};
        vecs[5]  = '{0, 1'b0, 32'h00,       32'h0,        32'h11112222};
        vecs[6]  = '{0, 1'b0, 32'h13,       32'h0,        32'hDEADBEEF};
        vecs[7]  = '{0, 1'b1, 32'h3C,       32'hCAFEF00D, 32'h0};
        vecs[8]  = '{0, 1'b0, 32'h3C,       32'h0,        32'hCAFEF00D};
        vecs[9]  = '{0, 1'b0, 32'h80000010, 32'h0,        32'h0};
        vecs[10] = '{0, 1'b1, 32'h08,       32'hA5A5A5A5, 32'h0};
        vecs[11] = '{0, 1'b1, 32'h14,       32'h00500093, 32'h0};
        vecs[12] = '{1, 1'b1, 32'h04,       32'h00500093, 32'h0};
        vecs[13] = '{1, 1'b1, 32'h08,       32'h0BADF00D, 32'h0};
        vecs[14] = '{1, 1'b0, 32'h04,       32'h0,        32'h00500093};

        for (int s = 0; s < 2; s++) begin
            flush[s] = 1'b0; ireq[s] = 1'b0; dr[s] = 1'b0; dw[s] = 1'b0;
            iaddr[s] = '0; daddr[s] = '0; wd[s] = '0;
            last_rd[s] = '0; last_id[s] = '0;
        end
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            check("reset instruction_response", {31'd0, iresp[s]}, 32'd0);
            check("reset data_memory_response", {31'd0, dresp[s]}, 32'd0);
            check("reset instruction_data", idata[s], 32'd0);
            check("reset read_data", rdata[s], 32'd0);
        end
        rst = 1'b0;

        for (int i = 0; i < 15; i++)
            data_txn(vecs[i].s, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].exp);

        instr_txn(0, 32'h14, 32'h00500093);
        instr_txn(0, 32'h16, 32'h00500093);
        instr_txn(1, 32'h04, 32'h00500093);
        instr_txn(1, 32'h06, 32'h00500093);
        check("read_data held after fetches", rdata[0], last_rd[0]);

        // Contention: data wins, fetch follows after the IDLE gap.
        last_rd[0] = 32'hDEADBEEF;
        qd0.push_back({1'b0, 32'hDEADBEEF});
        qi0.push_back(32'h00500093);
        @(negedge clk);
        dr[0] = 1'b1; daddr[0] = 32'h10; ireq[0] = 1'b1; iaddr[0] = 32'h14;
        k = 0; t_d = -1; t_i = -1;
        while (k < 20 && t_i < 0) begin
            @(posedge clk); #1; k++;
            if (dresp[0] && t_d < 0) begin t_d = k; dr[0] = 1'b0; end
            if (iresp[0]) begin t_i = k; ireq[0] = 1'b0; end
        end
        dr[0] = 1'b0; ireq[0] = 1'b0;
        check("contention data latency", t_d, 32'd2);
        check("contention fetch gap", t_i - t_d, 32'd3);
        @(posedge clk);

        // Flush in IDLE blocks the grant for that cycle only.
        qi0.push_back(32'h00500093);
        @(negedge clk);
        ireq[0] = 1'b1; iaddr[0] = 32'h14; flush[0] = 1'b1;
        k = 0;
        do begin
            @(posedge clk); #1; k++;
            flush[0] = 1'b0;
        end while (!iresp[0] && k < 20);
        ireq[0] = 1'b0;
        check("idle flush delays grant", k, 32'd3);
        @(posedge clk);

        // Flush during WAIT kills the fetch on the wait-state instance.
        @(negedge clk);
        ireq[1] = 1'b1; iaddr[1] = 32'h08;
        @(posedge clk); #1;
        flush[1] = 1'b1; ireq[1] = 1'b0;
        @(posedge clk); #1;
        flush[1] = 1'b0;
        seen = 0;
        repeat (8) begin
            @(posedge clk); #1;
            if (iresp[1]) seen++;
        end
        check("killed fetch no response", seen, 32'd0);
        check("killed fetch data held", idata[1], 32'h00500093);
        instr_txn(1, 32'h08, 32'h0BADF00D);

        // Reset during ACCESS of a store must not commit it.
        @(negedge clk);
        dw[0] = 1'b1; daddr[0] = 32'h08; wd[0] = 32'hFFFFFFFF;
        @(posedge clk); #1;
        rst = 1'b1; dw[0] = 1'b0;
        @(posedge clk); #1;
        check("mid-reset data_memory_response", {31'd0, dresp[0]}, 32'd0);
        check("mid-reset instruction_response", {31'd0, iresp[0]}, 32'd0);
        check("mid-reset instruction_data", idata[0], 32'd0);
        check("mid-reset read_data", rdata[0], 32'd0);
        check("mid-reset dut1 instruction_data", idata[1], 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int s = 0; s < 2; s++) begin
            last_rd[s] = '0; last_id[s] = '0;
        end
        data_txn(0, 1'b0, 32'h08, 32'h0, 32'hA5A5A5A5);
        data_txn(1, 1'b0, 32'h08, 32'h0, 32'h0BADF00D);

        repeat (4) @(posedge clk);
        check("data scoreboard drained", qd0.size() + qd1.size(), 32'd0);
        check("fetch scoreboard drained", qi0.size() + qi1.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
